// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI initiator block.
// Holds the state encoding, default data-path sizes, the idle slave-select
// value and the request-length clamp shared by the top level.
package spi_master_pkg;

  localparam int MAX_BITS_DEF = 64;
  localparam int LEN_W_DEF    = 7;
  localparam int SS_W_DEF     = 8;

  // All selects released (the pins are active-low)
  localparam logic [SS_W_DEF-1:0] SS_IDLE = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER_H,
    XFER_L,
    HOLD,
    DONE
  } state_t;

  // A zero or oversize request length means "a full-width transfer"
  function automatic int clamp_len(input int len, input int max_bits);
    return ((len == 0) || (len > max_bits)) ? max_bits : len;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/response handshake bundle for the SPI initiator.
// The "master" modport is the requesting agent; the "slave" modport is the
// SPI initiator itself, which serves requests and returns responses.
interface spi_master_if
  import spi_master_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int SS_W     = SS_W_DEF
);

  logic                req_valid;
  logic                req_ready;
  logic [LEN_W-1:0]    req_len;
  logic [MAX_BITS-1:0] req_data;
  logic [SS_W-1:0]     req_ss;
  logic [7:0]          req_div;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [MAX_BITS-1:0] rsp_data;

  modport master (
    output req_valid, req_len, req_data, req_ss, req_div, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_len, req_data, req_ss, req_div, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/spi_master_clkgen.sv
// Half-period timer for the SPI initiator.
// Loading with div makes tick appear div+1 clocks later; the owner reloads
// on every tick so each SETUP/XFER/HOLD phase lasts exactly div+1 clocks.
module spi_master_clkgen (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] count;

  // Down-counter that parks at zero until the next load
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= div;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tick = (count == 8'd0);

endmodule

// File: rtl/spi_master.sv
// SPI initiator: accepts one 1..MAX_BITS bit request, shifts it out on
// sck/mosi with a programmable half-period and returns the bits sampled on
// miso. MSB-first by default; defining SPI_MASTER_LSB_FIRST_EN sends bit 0
// of the request first and fills the response from bit 0 upward.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int SS_W     = SS_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  spi_master_if.slave     bus,
  output logic            sck,
  output logic [SS_W-1:0] ss,
  output logic            mosi,
  input  logic            miso
);

  state_t              state;
  logic [MAX_BITS-1:0] tx_sr;
  logic [MAX_BITS-1:0] rx_sr;
  logic [MAX_BITS-1:0] tx_load;
  logic [MAX_BITS-1:0] tx_next;
  logic [MAX_BITS-1:0] rx_next;
  logic                tx_bit;
  logic [LEN_W-1:0]    eff_len;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    bit_cnt;
  logic [7:0]          div_q;
  logic [7:0]          cg_div;
  logic                cg_load;
  logic                tick;
  logic                accept;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [MAX_BITS-1:0] rsp_data_q;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign accept  = bus.req_valid && req_ready_q;
  assign eff_len = LEN_W'(clamp_len(int'(bus.req_len), MAX_BITS));

  spi_master_clkgen u_clkgen (
    .clock (clock),
    .reset (reset),
    .load  (cg_load),
    .div   (cg_div),
    .tick  (tick)
  );

  // Bit-order dependent shift paths: next transmit bit, shifted tx image,
  // received image with the current miso folded in
  always_comb begin
    tx_load = '0;
    tx_next = '0;
    rx_next = '0;
    tx_bit  = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
    tx_load = bus.req_data;
    tx_bit  = tx_sr[0];
    tx_next = tx_sr >> 1;
    rx_next = rx_sr | (MAX_BITS'(miso) << bit_cnt);
`else
    tx_load = bus.req_data << (LEN_W'(MAX_BITS) - eff_len);
    tx_bit  = tx_sr[MAX_BITS-1];
    tx_next = tx_sr << 1;
    rx_next = {rx_sr[MAX_BITS-2:0], miso};
`endif
  end

  // Timer control: first load comes from the request itself, later loads
  // restart the half-period on every phase change
  always_comb begin
    cg_load = 1'b0;
    cg_div  = div_q;
    if (state == IDLE) begin
      cg_load = accept;
      cg_div  = bus.req_div;
    end else if ((state == SETUP) || (state == XFER_H) ||
                 (state == XFER_L) || (state == HOLD)) begin
      cg_load = tick;
    end
  end

  // Transfer sequencer with registered pin and handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      sck         <= 1'b0;
      ss          <= '1;
      mosi        <= 1'b1;
      tx_sr       <= '0;
      rx_sr       <= '0;
      len_q       <= '0;
      bit_cnt     <= '0;
      div_q       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sr       <= tx_load;
            rx_sr       <= '0;
            len_q       <= eff_len;
            bit_cnt     <= '0;
            div_q       <= bus.req_div;
            ss          <= ~bus.req_ss;
            req_ready_q <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sck   <= 1'b1;
            mosi  <= tx_bit;
            state <= XFER_H;
          end
        end
        XFER_H: begin
          if (tick) begin
            sck     <= 1'b0;
            rx_sr   <= rx_next;
            tx_sr   <= tx_next;
            bit_cnt <= bit_cnt + LEN_W'(1);
            state   <= XFER_L;
          end
        end
        XFER_L: begin
          if (tick) begin
            if (bit_cnt == len_q) begin
              state <= HOLD;
            end else begin
              sck   <= 1'b1;
              mosi  <= tx_bit;
              state <= XFER_H;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            ss          <= '1;
            mosi        <= 1'b1;
            rsp_data_q  <= rx_sr;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed requests with hand-computed
// responses go into a scoreboard queue; a monitor pops and compares on every
// response handshake. Loopback (miso=mosi) and a bit-reversal responder on
// ss[0] are selectable. Expectations follow SPI_MASTER_LSB_FIRST_EN.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int CLK_HALF = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sck;
  logic [7:0] ss;
  logic       mosi;
  logic       miso;
  logic       use_resp = 1'b0;
  logic       resp_miso = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  logic [7:0] r_in  = 8'h00;
  logic [7:0] r_out = 8'h00;
  int         r_cnt = 0;

  spi_master_if #(.MAX_BITS(64), .LEN_W(7), .SS_W(8)) bus ();

  spi_master dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .sck   (sck),
    .ss    (ss),
    .mosi  (mosi),
    .miso  (miso)
  );

  assign miso = use_resp ? resp_miso : mosi;

  // Free-running system clock
  always #CLK_HALF clock = ~clock;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Bit-reversal responder: shifts mosi in on falling sck, returns the
  // reversed first byte MSB-first during the second byte
  always @(negedge sck or posedge ss[0]) begin
    if (ss[0]) begin
      r_in = 8'h00; r_out = 8'h00; r_cnt = 0; resp_miso = 1'b0;
    end else begin
      r_in = {r_in[6:0], mosi};
      r_cnt++;
      if (r_cnt == 8) r_out = rev8(r_in);
      else            r_out = {r_out[6:0], 1'b0};
      resp_miso = r_out[7];
    end
  end

  // Scoreboard monitor: compare every accepted response against the queue
  always @(negedge clock) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL unexpected_rsp: got 0x%0h, expected no response", bus.rsp_data);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("rsp_data", bus.rsp_data, mon_exp);
      end
    end
  end

  // Hang guard
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [6:0] len, input logic [63:0] data,
                               input logic [7:0] sel, input logic [7:0] div,
                               input logic [63:0] exp, input bit expect_rsp);
    int waited = 0;
    while (!bus.req_ready && waited < 500) begin
      @(posedge clock); #1; waited++;
    end
    if (!bus.req_ready) checkOutput("req_ready_timeout", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_len   = len;
    bus.req_data  = data;
    bus.req_ss    = sel;
    bus.req_div   = div;
    if (expect_rsp) sb.push_back(exp);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  // Follows a transfer from the accept edge until rsp_valid, measuring
  // latency, sck pulses, phase lengths and select misbehaviour
  task automatic waitResponse(input logic [7:0] sel, output int cycles, output int pulses,
                              output int hi_min, output int hi_max,
                              output int lo_min, output int lo_max, output int ss_bad);
    bit prev = 1'b0;
    bit seen_fall = 1'b0;
    int hi_run = 0;
    int lo_run = 0;
    cycles = 1; pulses = 0; ss_bad = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    while (!bus.rsp_valid && cycles < 3000) begin
      @(posedge clock); #1;
      cycles++;
      if (!bus.rsp_valid) begin
        if (((ss | sel) != 8'hFF) || (sck && (ss != ~sel))) ss_bad++;
        if (sck) begin
          if (!prev) begin
            pulses++;
            if (seen_fall) begin
              if (lo_run < lo_min) lo_min = lo_run;
              if (lo_run > lo_max) lo_max = lo_run;
            end
            hi_run = 0;
          end
          hi_run++;
        end else begin
          if (prev) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            seen_fall = 1'b1;
            lo_run = 0;
          end
          lo_run++;
        end
        prev = sck;
      end
    end
    if (!bus.rsp_valid) checkOutput("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
  endtask

  initial begin
    int cyc, pul, hmin, hmax, lmin, lmax, sbad, waited, rises;
    logic prev_sck;
    logic [63:0] exp_rev;
    logic exp_first;

`ifdef SPI_MASTER_LSB_FIRST_EN
    exp_rev   = 64'h0000;
    exp_first = 1'b1;
`else
    exp_rev   = 64'h005C;
    exp_first = 1'b0;
`endif

    bus.req_valid = 1'b0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    bus.req_ss    = '0;
    bus.req_div   = '0;
    bus.rsp_ready = 1'b1;

    $display("[TB] reset");
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_rsp_data", bus.rsp_data, 64'd0);
    checkOutput("rst_sck", 64'(sck), 64'd0);
    checkOutput("rst_ss", 64'(ss), 64'(SS_IDLE));
    checkOutput("rst_mosi", 64'(mosi), 64'd1);
    reset = 1'b0;
    @(posedge clock); #1;

    $display("[TB] loopback len=8 data=A5 div=0");
    applyStimulus(7'd8, 64'hA5, 8'h02, 8'd0, 64'hA5, 1'b1);
    waitResponse(8'h02, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    checkOutput("lb8_pulses", 64'(pul), 64'd8);
    checkOutput("lb8_latency", 64'(cyc), 64'd19);
    checkOutput("lb8_ss_bad", 64'(sbad), 64'd0);
    checkOutput("lb8_req_ready_busy", 64'(bus.req_ready), 64'd0);
    checkOutput("lb8_ss_done", 64'(ss), 64'hFF);
    @(posedge clock); #1;
    checkOutput("lb8_valid_one_cycle", 64'(bus.rsp_valid), 64'd0);
    checkOutput("lb8_idle_ready", 64'(bus.req_ready), 64'd1);

    $display("[TB] bit-reversal responder len=16 data=3A00 div=3");
    use_resp = 1'b1;
    applyStimulus(7'd16, 64'h3A00, 8'h01, 8'd3, exp_rev, 1'b1);
    waitResponse(8'h01, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    checkOutput("rev_pulses", 64'(pul), 64'd16);
    checkOutput("rev_latency", 64'(cyc), 64'd137);
    checkOutput("rev_hi_min", 64'(hmin), 64'd4);
    checkOutput("rev_hi_max", 64'(hmax), 64'd4);
    checkOutput("rev_lo_min", 64'(lmin), 64'd4);
    checkOutput("rev_lo_max", 64'(lmax), 64'd4);
    checkOutput("rev_ss_bad", 64'(sbad), 64'd0);
    checkOutput("rev_ss_done", 64'(ss), 64'hFF);
    @(posedge clock); #1;
    use_resp = 1'b0;

    $display("[TB] loopback len=1 data=1 div=0");
    applyStimulus(7'd1, 64'h1, 8'h04, 8'd0, 64'h1, 1'b1);
    waitResponse(8'h04, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    checkOutput("len1_pulses", 64'(pul), 64'd1);
    checkOutput("len1_latency", 64'(cyc), 64'd5);

    $display("[TB] loopback len=0 (full width)");
    applyStimulus(7'd0, 64'hDEAD_BEEF_0123_4567, 8'h08, 8'd0, 64'hDEAD_BEEF_0123_4567, 1'b1);
    waitResponse(8'h08, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    checkOutput("len0_pulses", 64'(pul), 64'd64);
    checkOutput("len0_latency", 64'(cyc), 64'd131);

    $display("[TB] loopback len=100 (oversize)");
    applyStimulus(7'd100, 64'h8000_0000_0000_0001, 8'h80, 8'd0, 64'h8000_0000_0000_0001, 1'b1);
    waitResponse(8'h80, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    checkOutput("len100_pulses", 64'(pul), 64'd64);

    $display("[TB] first bit order len=8 data=01 div=1");
    applyStimulus(7'd8, 64'h01, 8'h10, 8'd1, 64'h01, 1'b1);
    waited = 0;
    while (!sck && waited < 100) begin
      @(posedge clock); #1; waited++;
    end
    checkOutput("order_sck_seen", 64'(sck), 64'd1);
    checkOutput("order_first_mosi", 64'(mosi), 64'(exp_first));
    waitResponse(8'h10, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    @(posedge clock); #1;

    $display("[TB] response back-pressure");
    bus.rsp_ready = 1'b0;
    applyStimulus(7'd4, 64'h9, 8'h20, 8'd0, 64'h9, 1'b1);
    waitResponse(8'h20, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    bus.req_valid = 1'b1;
    bus.req_len   = 7'd4;
    bus.req_data  = 64'h6;
    bus.req_ss    = 8'h40;
    bus.req_div   = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checkOutput("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("stall_rsp_data", bus.rsp_data, 64'h9);
      checkOutput("stall_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    sb.push_back(64'h6);
    @(posedge clock); #1;
    checkOutput("stall_release_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("stall_release_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    checkOutput("stall_second_accepted", 64'(bus.req_ready), 64'd0);
    waitResponse(8'h40, cyc, pul, hmin, hmax, lmin, lmax, sbad);
    checkOutput("stall_second_latency", 64'(cyc), 64'd11);
    @(posedge clock); #1;

    $display("[TB] reset during bit 5");
    applyStimulus(7'd8, 64'h00, 8'h01, 8'd2, 64'h0, 1'b0);
    rises = 0;
    waited = 0;
    prev_sck = 1'b0;
    while (rises < 6 && waited < 500) begin
      @(posedge clock); #1; waited++;
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
    end
    checkOutput("abort_reached_bit5", 64'(rises), 64'd6);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("abort_sck", 64'(sck), 64'd0);
    checkOutput("abort_ss", 64'(ss), 64'hFF);
    checkOutput("abort_mosi", 64'(mosi), 64'd1);
    checkOutput("abort_req_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("abort_rsp_data", bus.rsp_data, 64'd0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator (bus-side master) for the NPC peripheral subsystem; drives sck/ss/mosi towards SPI responders such as the bit-reversal test device, and samples miso.
- Accepts one transfer request of 1..MAX_BITS bits through a valid/ready handshake, serialises it MSB-first and returns the received bits through a valid/ready response.
- Single clock domain; sck is derived from `clock` by a programmable divider.

Parameters:
- MAX_BITS, 64, maximum bits per transfer; width of the data paths.
- LEN_W, 7, width of req_len; must satisfy 2^LEN_W > MAX_BITS.
- SS_W, 8, number of slave-select lines.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  transfer request valid
- req_ready  out  1  block idle, request accepted when req_valid && req_ready
- req_len  in  LEN_W  bit count, 1..MAX_BITS
- req_data  in  MAX_BITS  tx bits, right-aligned; bit req_len-1 is sent first
- req_ss  in  SS_W  one-hot select to assert (active-low on the pins)
- req_div  in  8  sck half-period = req_div+1 clocks
- rsp_valid  out  1  received data available
- rsp_ready  in  1  consumer accepts rsp_data
- rsp_data  out  MAX_BITS  rx bits, right-aligned, first received bit at req_len-1
- sck  out  1  serial clock, idle low
- ss  out  SS_W  active-low selects, idle all-ones
- mosi  out  1  serial out
- miso  in  1  serial in

Behaviour:
- Reset (sync, high): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, sck=0, ss=all-ones, mosi=1; reset mid-transfer aborts immediately with the same values.
- Request latched on handshake: tx shift register, len, ss mask, div; req_len=0 or >MAX_BITS is treated as MAX_BITS.
- States: IDLE -> SETUP -> XFER_H -> XFER_L -> (XFER_H | HOLD) -> DONE -> IDLE.
- IDLE: req_ready=1; on accept go to SETUP, drive ss=~req_ss.
- SETUP: wait div+1 clocks with ss asserted, sck=0 (cs-to-sck setup).
- XFER_H entry: sck<=1, mosi<=current MSB of tx shift; hold div+1 clocks.
- XFER_L entry: sck<=0; in the same clock edge capture miso into rx shift (value present before the falling sck edge); bit counter++; hold div+1 clocks. Then XFER_H if bits remain, otherwise HOLD.
- Responder contract: samples mosi on falling sck, updates miso on falling sck; the first rx bit is therefore whatever miso shows during bit 0.
- HOLD: div+1 clocks with sck=0, then ss<=all-ones, mosi<=1.
- DONE: rsp_valid=1, rsp_data stable until rsp_ready; return to IDLE in the cycle after the handshake. rsp_ready held high means rsp_valid is high for exactly 1 cycle.
- Transfer length: exactly len rising sck edges. Total clocks from accept to rsp_valid = (div+1)*(2*len+2)+1.
- Half-period counter wraps to 0 on each phase change; req_div=0 gives sck = clock/2.
- req_valid is ignored outside IDLE; no queueing.

Optional Feature:
- Macro SPI_MASTER_LSB_FIRST_EN.
- Defined: bit 0 of req_data is sent first, and received bits fill rsp_data from bit 0 upward.
- Undefined: MSB-first as above.
- Ports are unchanged in both builds.

Decomposition:
- spi_pkg: state enum (IDLE, SETUP, XFER_H, XFER_L, HOLD, DONE), default MAX_BITS, SS idle constant.
- Sub-module spi_clkgen: half-period down-counter with load(div) and a tick output. spi_master uses it for SETUP, XFER and HOLD timing.

Test Plan:
- Loopback (mosi tied to miso), len=8, data=0xA5, div=0 -> rsp_data=0xA5; exactly 8 sck pulses; accept-to-rsp_valid = 19 clocks.
- Bit-reversal responder on ss[0], len=16, data=0x3A00, div=3 -> ss[0] low only during the transfer; each sck high/low phase is 4 clocks; rsp_data[7:0] equals the responder's returned byte; ss[7:1] stay high.
- len=1, data=1, div=0, loopback -> 1 sck pulse, rsp_data=1; len=0 -> MAX_BITS pulses.
- rsp_ready held low 10 cycles after DONE -> rsp_valid and rsp_data stable and req_ready=0 throughout; new req_valid is not accepted until after the response handshake.
- Assert reset during XFER_H of bit 5 -> next cycle sck=0, ss=0xFF, mosi=1, req_ready=1, rsp_valid=0.
- Build with SPI_MASTER_LSB_FIRST_EN, loopback, len=8, data=0x01 -> first mosi bit is 1 and rsp_data=0x01.
